mips_mmio_sevenseg: RTL and testbench
=====================================

Name: mips_mmio_sevenseg

Overview:
Memory-mapped responder on the single-cycle MIPS core's data-memory bus (memwrite/memaddr/memwritedata/memreaddata). It decodes a small address window and holds a 32-bit display register, a control register and a free-running cycle counter. It drives a time-multiplexed, active-low hex seven-segment display. The top level muxes this block's read data against data memory using its hit flag.

Parameters:
BASE_ADDR, 32'hFFFF_0000, word-aligned base of the 16-byte register window.
NDIGITS, 8, number of display digits (1..8); digit i shows DATA[4i+3:4i].
SCAN_DIV, 50000, clocks per digit slot (>=2).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
memwrite  input  1  store strobe from core
memaddr  input  32  byte address from core
memwritedata  input  32  store data
hit  output  1  memaddr[31:4]==BASE_ADDR[31:4] (combinational)
rdata  output  32  read data for current memaddr (combinational)
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
an  output  NDIGITS  digit anodes, active-low

Behaviour:
- Register map (offset = memaddr[3:2]):
  - 0 DATA, RW, reset 0.
  - 1 CTRL, RW: [7:0] digit-enable mask (reset 8'hFF), [8] blank (reset 0), [16:9] dp mask (reset 0); other bits read 0.
  - 2 CYCLE, RW: reset 0.
  - 3 reserved: reads 0, writes ignored.
- memaddr[1:0] is ignored; there are no byte or half-word writes.
- Write: on a rising clk edge with memwrite & hit, the selected register loads memwritedata. There is no wait state.
- Read: rdata is the selected register, same cycle, purely combinational, because the single-cycle core needs the result in the same cycle. rdata=0 when hit=0.
- CYCLE: increments by 1 every clk and wraps 32'hFFFF_FFFF -> 0. A write in the same edge takes priority, loading the written value; the increment applies from the next edge.
- Scan FSM:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count, digit index advances idx -> (idx==NDIGITS-1 ? 0 : idx+1).
  - Reset gives prescaler 0, idx 0.
- Output stage (registered, 1 clk after idx/DATA/CTRL change):
  - an[idx]=0 only if CTRL[idx]=1 and blank=0; all other an bits are 1.
  - seg = hex decode of the current nibble. Patterns: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A=7'b0001000, F=7'b0001110.
  - dp = ~CTRL[9+idx].
  - When the digit is disabled or blanked, seg=7'h7F and dp=1.
- Reset values: seg=7'h7F, dp=1, an all ones, first digit driven on the cycle after reset release.
- Asserting reset mid-slot immediately clears registers, prescaler and idx, and blanks all outputs (asynchronous).
- A DATA write mid-slot updates the lit digit 1 clk later. There is no tearing protection.

Optional Feature:
SEVENSEG_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digit i is forced dark (an=1, seg=7'h7F) when DATA nibbles NDIGITS-1 down to i are all zero and i!=0. Digit 0 always shows, so DATA=0 displays a single "0".
- Undefined: all enabled digits display, including leading zeros.

Decomposition:
- Shared package mmio_pkg holds:
  - register offset constants: DATA=2'd0, CTRL=2'd1, CYCLE=2'd2;
  - CTRL field positions and reset values;
  - seg7 pattern constants for 0-F and SEG_OFF.
- Sub-module hex_to_seg7 (combinational 4-bit -> 7-bit active-low decoder) is instantiated once, on the selected nibble.

Test Plan:
- Reset: hold reset=0 mid-count, then release -> seg=7'h7F, an=8'hFF, dp=1 during reset. CYCLE reads 0 at the first edge after release. DATA and CTRL read 0 and 32'h0000_00FF.
- Write/read: store 32'h1234_ABCD to BASE+0, then read BASE+0 -> rdata=32'h1234_ABCD in the same cycle as the read. Read of BASE+12 gives 0. memaddr=32'h0000_0040 gives hit=0, rdata=0.
- Scan (SCAN_DIV=4, DATA=32'h8765_4321): an walks FE, FD, FB, ... 7F, FE, changing every 4 clks. When an=FE, seg=7'b1111001 ("1").
- Mask/blank: CTRL=32'h0000_0005 -> only an bits 0 and 2 ever go low. CTRL bit 8 set -> an stays FF.
- CYCLE collision: write 32'hFFFF_FFFE to BASE+8 -> reads FFFF_FFFE, FFFF_FFFF, 0000_0000 on consecutive cycles.
- With SEVENSEG_LZ_BLANK_EN, DATA=32'h0000_00A0 -> only digits 1 (seg=7'b0001000) and 0 (seg=7'b1000000) light.

Source files
------------

// File: rtl/mips_mmio_sevenseg_pkg.sv
// Shared register-map, CTRL layout and seven-segment pattern constants.
// Latency: n/a (constants only).  Backpressure: n/a.
package mmio_pkg;

    localparam logic [1:0] DATA  = 2'd0;
    localparam logic [1:0] CTRL  = 2'd1;
    localparam logic [1:0] CYCLE = 2'd2;

    localparam int CTRL_EN_LSB    = 0;
    localparam int CTRL_BLANK_BIT = 8;
    localparam int CTRL_DP_LSB    = 9;
    localparam int CTRL_W         = 17;

    typedef struct packed {
        logic [7:0] dp_mask;
        logic       blank;
        logic [7:0] en_mask;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{dp_mask: 8'h00, blank: 1'b0, en_mask: 8'hFF};

    // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/mips_mmio_sevenseg_hex_to_seg7.sv
// Hex nibble to active-low seven-segment glyph decoder.
// Latency: combinational.  Backpressure: none.
module hex_to_seg7
    import mmio_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/mips_mmio_sevenseg.sv
// MMIO DATA/CTRL/CYCLE registers plus multiplexed hex display; SEVENSEG_LZ_BLANK_EN adds leading-zero blanking.
// Latency: reads combinational, writes 1 clk, display outputs 1 clk after idx/DATA/CTRL.  Backpressure: none (no wait states).
module mips_mmio_sevenseg
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          NDIGITS   = 8,
    parameter int          SCAN_DIV  = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memwrite,
    input  logic [31:0]        memaddr,
    input  logic [31:0]        memwritedata,
    output logic               hit,
    output logic [31:0]        rdata,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [NDIGITS-1:0] an
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [31:0]        data_q;
    logic [31:0]        cycle_q;
    ctrl_t              ctrl_q;
    logic [PW-1:0]      pre_q;
    logic [IW-1:0]      idx_q;
    logic [1:0]         off;
    logic               wr;
    logic [3:0]         nib;
    logic [6:0]         dec_seg;
    logic               lz_dark;
    logic               lit;
    logic [NDIGITS-1:0] an_nxt;
    logic               unused_addr_lsbs;

    assign hit              = (memaddr[31:4] == BASE_ADDR[31:4]);
    assign off              = memaddr[3:2];
    assign wr               = memwrite & hit;
    assign unused_addr_lsbs = ^memaddr[1:0];

    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (off)
                DATA:    rdata = data_q;
                CTRL:    rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
                CYCLE:   rdata = cycle_q;
                default: rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= 32'h0;
            ctrl_q  <= CTRL_RESET;
            cycle_q <= 32'h0;
        end else begin
            if (wr && off == DATA) data_q <= memwritedata;
            if (wr && off == CTRL) ctrl_q <= ctrl_t'(memwritedata[CTRL_W-1:0]);
            // A store to CYCLE wins over the free-running increment on that edge.
            if (wr && off == CYCLE) cycle_q <= memwritedata;
            else                    cycle_q <= cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    assign nib = data_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

`ifdef SEVENSEG_LZ_BLANK_EN
    logic zero_up;
    always_comb begin
        zero_up = 1'b1;
        for (int j = 0; j < NDIGITS; j++) begin
            if (IW'(j) >= idx_q && data_q[4*j +: 4] != 4'h0) zero_up = 1'b0;
        end
        // Digit 0 is never suppressed so an all-zero value still shows "0".
        lz_dark = (idx_q != '0) && zero_up;
    end
`else
    assign lz_dark = 1'b0;
`endif

    assign lit = ctrl_q.en_mask[idx_q] & ~ctrl_q.blank & ~lz_dark;

    always_comb begin
        an_nxt        = '1;
        an_nxt[idx_q] = ~lit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_OFF;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= lit ? dec_seg : SEG_OFF;
            dp  <= lit ? ~ctrl_q.dp_mask[idx_q] : 1'b1;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_mips_mmio_sevenseg.sv
// Randomised MMIO/display bench against a behavioural model, plus directed literal checks.
module tb_mips_mmio_sevenseg;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int          NDIG = 8;
    localparam int          SDIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic        hit;
    logic [31:0] rdata;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;

    mips_mmio_sevenseg #(
        .BASE_ADDR (BASE),
        .NDIGITS   (NDIG),
        .SCAN_DIV  (SDIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .hit          (hit),
        .rdata        (rdata),
        .seg          (seg),
        .dp           (dp),
        .an           (an)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [31:0] m_data, m_ctrl, m_cycle;
    longint      m_n;
    logic [6:0]  e_seg;
    logic [7:0]  e_an;
    logic        e_dp;
    int          m_idx;
    logic [31:0] m_sh;
    logic        m_lit;

    function automatic logic m_hit(input logic [31:0] a);
        return (a & 32'hFFFF_FFF0) == BASE;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[3:2])
            2'd0:    return m_data;
            2'd1:    return m_ctrl & 32'h0001_FFFF;
            2'd2:    return m_cycle;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_data  = 32'h0;
            m_ctrl  = 32'hFF;
            m_cycle = 32'h0;
            m_n     = 0;
            e_seg   = 7'h7F;
            e_an    = 8'hFF;
            e_dp    = 1'b1;
        end else begin
            // Digit shown after this edge: slot number = edges so far / SDIV.
            m_idx = int'((m_n / SDIV) % NDIG);
            m_sh  = m_data >> (4 * m_idx);
            m_lit = m_ctrl[m_idx] && !m_ctrl[8];
`ifdef SEVENSEG_LZ_BLANK_EN
            if (m_idx != 0 && m_sh == 32'h0) m_lit = 1'b0;
`endif
            e_an = 8'hFF;
            if (m_lit) e_an[m_idx] = 1'b0;
            e_seg = m_lit ? seg_tbl[m_sh[3:0]] : 7'h7F;
            e_dp  = m_lit ? ~m_ctrl[9 + m_idx] : 1'b1;
            m_n++;
            if (memwrite && m_hit(memaddr) && memaddr[3:2] == 2'd0) m_data = memwritedata;
            if (memwrite && m_hit(memaddr) && memaddr[3:2] == 2'd1) m_ctrl = memwritedata;
            if (memwrite && m_hit(memaddr) && memaddr[3:2] == 2'd2) m_cycle = memwritedata;
            else                                                     m_cycle = m_cycle + 32'd1;
        end
    end

    always @(negedge clk) begin
        check("seg",   {25'h0, seg}, {25'h0, e_seg});
        check("an",    {24'h0, an},  {24'h0, e_an});
        check("dp",    {31'h0, dp},  {31'h0, e_dp});
        check("hit",   {31'h0, hit}, {31'h0, m_hit(memaddr)});
        check("rdata", rdata,        m_rdata(memaddr));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #2;
        memwrite     = we;
        memaddr      = a;
        memwritedata = wd;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, a, 32'h0);
        @(negedge clk);
        check(name, rdata, exp);
    endtask

    logic [7:0]  prev_an, acc;
    int          run, nchg;
    bit          seen;
    logic [31:0] ra, wd;

    initial begin
        reset = 1'b0; memwrite = 1'b0; memaddr = BASE; memwritedata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_seg", {25'h0, seg}, 32'h7F);
        check("rst_an",  {24'h0, an},  32'hFF);
        check("rst_dp",  {31'h0, dp},  32'h1);
        check("rst_data", rdata, 32'h0);
        memaddr = BASE + 4;
        #1 check("rst_ctrl", rdata, 32'h0000_00FF);
        memaddr = BASE + 8;
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        check("rst_cycle", rdata, 32'h0);
        @(negedge clk);
        check("first_an",  {24'h0, an},  32'hFE);
        check("first_seg", {25'h0, seg}, 32'h40);

        // Write/read, reserved slot, miss.
        drive(1'b1, BASE, 32'h1234_ABCD);
        rd_check("rd_data", BASE, 32'h1234_ABCD);
        drive(1'b1, BASE + 12, 32'hDEAD_BEEF);
        rd_check("rd_rsvd", BASE + 12, 32'h0);
        drive(1'b0, 32'h0000_0040, 32'h0);
        @(negedge clk);
        check("miss_hit", {31'h0, hit}, 32'h0);
        check("miss_rdata", rdata, 32'h0);

        // CYCLE load collides with increment.
        drive(1'b1, BASE + 8, 32'hFFFF_FFFE);
        rd_check("cyc0", BASE + 8, 32'hFFFF_FFFE);
        rd_check("cyc1", BASE + 8, 32'hFFFF_FFFF);
        rd_check("cyc2", BASE + 8, 32'h0000_0000);

        // Scan walk.
        drive(1'b1, BASE + 4, 32'h0000_00FF);
        drive(1'b1, BASE,     32'h8765_4321);
        drive(1'b0, 32'h40, 32'h0);
        @(negedge clk);
        prev_an = an; run = 1; nchg = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 32'h40, 32'h0);
            @(negedge clk);
            if (an != prev_an) begin
                check("scan_rot", {24'h0, an}, {24'h0, prev_an[6:0], prev_an[7]});
                if (seen) check("scan_len", run, 4);
                seen = 1'b1; nchg++; run = 1; prev_an = an;
            end else begin
                run++;
            end
            if (an == 8'hFE) check("scan_d0", {25'h0, seg}, 32'h79);
            if (an == 8'hFD) check("scan_d1", {25'h0, seg}, 32'h24);
        end
        check("scan_nchg_ge9", {31'h0, nchg >= 9}, 32'h1);

        // Digit mask.
        drive(1'b1, BASE + 4, 32'h0000_0005);
        drive(1'b0, 32'h40, 32'h0);
        acc = 8'h00;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 32'h40, 32'h0);
            @(negedge clk);
            acc |= ~an;
        end
        check("mask_lit", {24'h0, acc}, 32'h05);

        // Blank.
        drive(1'b1, BASE + 4, 32'h0000_01FF);
        drive(1'b0, 32'h40, 32'h0);
        acc = 8'h00;
        for (int i = 0; i < 36; i++) begin
            drive(1'b0, 32'h40, 32'h0);
            @(negedge clk);
            acc |= ~an;
        end
        check("blank_lit", {24'h0, acc}, 32'h00);

`ifdef SEVENSEG_LZ_BLANK_EN
        drive(1'b1, BASE + 4, 32'h0000_00FF);
        drive(1'b1, BASE,     32'h0000_00A0);
        drive(1'b0, 32'h40, 32'h0);
        acc = 8'h00;
        for (int i = 0; i < 36; i++) begin
            drive(1'b0, 32'h40, 32'h0);
            @(negedge clk);
            acc |= ~an;
            if (an == 8'hFD) check("lz_d1", {25'h0, seg}, 32'h08);
            if (an == 8'hFE) check("lz_d0", {25'h0, seg}, 32'h40);
        end
        check("lz_lit", {24'h0, acc}, 32'h03);
`endif

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 9))
                7:       ra = BASE + 32'd16 + $urandom_range(0, 255);
                8:       ra = $urandom;
                9:       ra = BASE - 32'd4;
                default: ra = BASE + $urandom_range(0, 15);
            endcase
            wd = $urandom;
            if ($urandom_range(0, 3) != 0) wd[8] = 1'b0;
            drive($urandom_range(0, 3) == 0, ra, wd);
            if (i == 1000) begin
                #1 reset = 1'b0;
                memwrite = 1'b0;
                repeat (3) @(negedge clk);
                @(posedge clk); #2 reset = 1'b1;
            end
        end
        drive(1'b0, 32'h40, 32'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
